poker_payout: RTL and testbench
===============================

Name: poker_payout

Overview:
- Sits directly downstream of the hand judge; consumes its 4-bit hand code and double-up-chance flag.
- Converts the hand into a win amount (bet × multiplier) and credits it to a player balance.
- When double-up is offered, runs the high/low double-up game against cards from the dealer stage.
- Collects the final winnings into the credit register.

Parameters:
- MAX_ROUNDS, 10, maximum double-up wins before forced collect (1..15).
- WIN_MAX, 16'd50000, saturation cap on win_amt; reaching it forces collect.

Ports:
- clock  in  1  system clock, rising edge
- reset_c  in  1  asynchronous active-low reset
- hand_r  in  4  hand code from judge; 4'b1111 = no result
- dchance1  in  1  double-up offered (from judge, sampled with hand_r)
- bet  in  4  bet units 0..15, sampled at hand accept
- take  in  1  player collects (level, sampled in OFFER)
- dbl  in  1  player chooses double-up (sampled in OFFER)
- guess_hi  in  1  guess next card higher (sampled in GUESS)
- guess_lo  in  1  guess next card lower (sampled in GUESS)
- dcard_num  in  4  double-up card rank 1..13 (1 = ace)
- dcard_valid  in  1  dcard_num valid this cycle
- win_amt  out  16  current pending winnings
- credit  out  16  player balance, saturating
- offer  out  1  high in OFFER
- need_card  out  1  high in REF or DRAW
- need_guess  out  1  high in GUESS
- dresult  out  2  last double-up outcome: 00 none, 01 win, 10 lose, 11 push
- done  out  1  one-cycle pulse when a hand is fully settled
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_c=0) values:
  - State IDLE; win_amt=0, credit=0, dresult=00, done=0.
  - Round count 0; armed=1.
  - A reset mid-game discards everything, including credit.
- Accept:
  - In IDLE with armed=1 and hand_r != 4'b1111, the next edge latches the hand and clears armed.
  - armed re-sets on any cycle where hand_r == 4'b1111, so a held result is counted once.
  - Results arriving outside IDLE are ignored; they do not clear armed.
- Multiplier table:
  - 0000 → 0, 0001 → 1, 0010 → 2, 0011 → 3, 0100 → 4, 0101 → 5.
  - 0110 → 10, 0111 → 20, 1000 → 25, 1010 → 250.
  - All other codes → 0.
- win_amt is set to bet × multiplier on the accept edge (max 3750, no overflow). dresult is cleared to 00 on the same edge.
- Next state after accept:
  - win_amt == 0 → COLLECT.
  - win_amt != 0 and dchance1 = 1 → OFFER.
  - Otherwise → COLLECT.
- OFFER:
  - take=1 → COLLECT (take has priority when take and dbl are both high).
  - dbl=1 → REF.
  - Otherwise hold.
- REF: on dcard_valid with rank 1..13, store it as the reference card → GUESS. Invalid ranks (0, 14, 15) are ignored.
- GUESS:
  - Exactly one of guess_hi / guess_lo high → latch the guess → DRAW.
  - Both high or neither high → hold.
- DRAW: on a valid dcard_valid, compare ranks with ace mapped to 14.
  - Correct guess: win_amt = min(2 × win_amt, WIN_MAX); round+1; dresult=01.
    - If round == MAX_ROUNDS or win_amt == WIN_MAX → COLLECT.
    - Otherwise the drawn card becomes the new reference → OFFER.
  - Equal ranks: dresult=11; win_amt unchanged; round unchanged; drawn card becomes the reference → OFFER.
  - Wrong guess: dresult=10; win_amt=0 → COLLECT.
- COLLECT (one cycle):
  - credit = min(credit + win_amt, 16'hFFFF).
  - round=0; → IDLE.
  - done pulses high for exactly the cycle after COLLECT.
- Latency:
  - No-chance hand: accept edge → COLLECT → done, visible 2 cycles after accept.
  - Outputs are registered; offer, need_card, need_guess and busy decode the registered state.

Decomposition:
- Shared package:
  - Hand-code constants (HAND_NONE … HAND_RSF, HAND_IDLE = 4'b1111), also used by the judge.
  - State enum: IDLE, OFFER, REF, GUESS, DRAW, COLLECT.
  - dresult encodings.
- Natural sub-module: payout_mult, a pure combinational hand-code → 8-bit multiplier lookup.

Test Plan:
- Reset mid-play: reset during GUESS with credit=500 → credit=0, state IDLE, busy=0 immediately.
- One pair, no double-up: hand_r=0001, dchance1=0, bet=5, held 3 cycles then 1111 → win_amt=5, credit=5, exactly one done pulse.
- Double-up win then collect: hand_r=0011, dchance1=1, bet=10 → win_amt=30, then:
  - dbl, ref=7, guess_hi, draw=1 (ace) → win_amt=60, dresult=01, back in OFFER.
  - take → credit=60.
- Push then loss: hand 0101, bet 2 → win_amt 10, then:
  - dbl, ref=9, guess_lo, draw=9 → dresult=11, win_amt=10.
  - dbl, guess_lo, draw=12 → dresult=10, win_amt=0, credit unchanged.
- Caps: royal 1010, bet 15 → win_amt 3750; four correct guesses → 7500, 15000, 30000, then 50000 (saturated) → auto COLLECT, credit=50000. A second royal with the same bet → credit saturates at 65535.
- Illegal and conflicting inputs:
  - hand_r=1011 → win_amt=0, done.
  - In OFFER, take=dbl=1 → COLLECT.
  - In GUESS, guess_hi=guess_lo=1 → stays in GUESS.
  - In REF, dcard_num=0 with dcard_valid=1 → stays in REF.

Source files
------------

// File: rtl/poker_payout_pkg.sv
// Shared definitions for the payout stage: hand codes from the judge, FSM states,
// double-up result encodings and card-rank helpers.
package poker_payout_pkg;

  localparam logic [3:0] HAND_NONE       = 4'b0000;
  localparam logic [3:0] HAND_PAIR       = 4'b0001;
  localparam logic [3:0] HAND_TWO_PAIR   = 4'b0010;
  localparam logic [3:0] HAND_TRIPS      = 4'b0011;
  localparam logic [3:0] HAND_STRAIGHT   = 4'b0100;
  localparam logic [3:0] HAND_FLUSH      = 4'b0101;
  localparam logic [3:0] HAND_FULL_HOUSE = 4'b0110;
  localparam logic [3:0] HAND_QUADS      = 4'b0111;
  localparam logic [3:0] HAND_SF         = 4'b1000;
  localparam logic [3:0] HAND_RSF        = 4'b1010;
  localparam logic [3:0] HAND_IDLE       = 4'b1111;

  localparam int          MAX_ROUNDS_DEF = 10;
  localparam logic [15:0] WIN_MAX_DEF    = 16'd50000;

  typedef enum logic [2:0] {IDLE, OFFER, REF, GUESS, DRAW, COLLECT} state_t;

  localparam logic [1:0] DRES_NONE = 2'b00;
  localparam logic [1:0] DRES_WIN  = 2'b01;
  localparam logic [1:0] DRES_LOSE = 2'b10;
  localparam logic [1:0] DRES_PUSH = 2'b11;

  // Ace ranks above king in the high/low game.
  function automatic logic [3:0] rank_value(input logic [3:0] r);
    return (r == 4'd1) ? 4'd14 : r;
  endfunction

  function automatic logic rank_ok(input logic [3:0] r);
    return (r != 4'd0) && (r <= 4'd13);
  endfunction

endpackage

// File: rtl/poker_payout_if.sv
// Player/judge/dealer-facing signal bundle of the payout stage, plus the FSM debug view.
interface poker_payout_if;
  import poker_payout_pkg::*;

  logic [3:0]  hand_r;
  logic        dchance1;
  logic [3:0]  bet;
  logic        take;
  logic        dbl;
  logic        guess_hi;
  logic        guess_lo;
  // dcard_num is consumed on a cycle where dcard_valid is high while need_card
  // (the ready side) is high; valid cards offered at other times are dropped.
  logic [3:0]  dcard_num;
  logic        dcard_valid;

  logic [15:0] win_amt;
  logic [15:0] credit;
  logic        offer;
  logic        need_card;
  logic        need_guess;
  logic [1:0]  dresult;
  logic        done;
  logic        busy;
  state_t      dbg_state;

  modport master (
    output hand_r, dchance1, bet, take, dbl, guess_hi, guess_lo, dcard_num, dcard_valid,
    input  win_amt, credit, offer, need_card, need_guess, dresult, done, busy, dbg_state
  );

  modport slave (
    input  hand_r, dchance1, bet, take, dbl, guess_hi, guess_lo, dcard_num, dcard_valid,
    output win_amt, credit, offer, need_card, need_guess, dresult, done, busy, dbg_state
  );
endinterface

// File: rtl/poker_payout_mult.sv
// Combinational hand-code to payout-multiplier lookup.
module payout_mult
  import poker_payout_pkg::*;
(
  input  logic [3:0] i_hand,
  output logic [7:0] o_mult
);

  always_comb begin
    o_mult = 8'd0;
    case (i_hand)
      HAND_PAIR:       o_mult = 8'd1;
      HAND_TWO_PAIR:   o_mult = 8'd2;
      HAND_TRIPS:      o_mult = 8'd3;
      HAND_STRAIGHT:   o_mult = 8'd4;
      HAND_FLUSH:      o_mult = 8'd5;
      HAND_FULL_HOUSE: o_mult = 8'd10;
      HAND_QUADS:      o_mult = 8'd20;
      HAND_SF:         o_mult = 8'd25;
      HAND_RSF:        o_mult = 8'd250;
      default:         o_mult = 8'd0;
    endcase
  end

endmodule

// File: rtl/poker_payout.sv
// Payout stage: turns a judged hand into winnings, runs the high/low double-up
// game, and settles the result into the saturating credit register.
module poker_payout
  import poker_payout_pkg::*;
#(
  parameter int          MAX_ROUNDS = MAX_ROUNDS_DEF,
  parameter logic [15:0] WIN_MAX    = WIN_MAX_DEF
) (
  input  logic           clock,
  input  logic           reset_c,
  poker_payout_if.slave  bus
);

  localparam logic [3:0] LP_MAX_ROUNDS = MAX_ROUNDS[3:0];

  state_t      r_state;
  logic [15:0] r_win;
  logic [15:0] r_credit;
  logic [1:0]  r_dres;
  logic        r_done;
  logic        r_armed;
  logic        r_guess_hi;
  logic        r_have_ref;
  logic [3:0]  r_ref;
  logic [3:0]  r_round;

  logic [7:0]  w_mult;
  logic [11:0] w_prod;
  logic [16:0] w_dbl;
  logic [15:0] w_win_dbl;
  logic [16:0] w_sum;
  logic        w_card_ok;
  logic [3:0]  w_draw_v;
  logic [3:0]  w_ref_v;
  logic        w_push;
  logic        w_hit;
  logic [3:0]  w_round_inc;

  payout_mult u_mult (
    .i_hand (bus.hand_r),
    .o_mult (w_mult)
  );

  assign w_prod      = {8'd0, bus.bet} * {4'd0, w_mult};
  assign w_dbl       = {r_win, 1'b0};
  assign w_win_dbl   = (w_dbl >= {1'b0, WIN_MAX}) ? WIN_MAX : w_dbl[15:0];
  assign w_sum       = {1'b0, r_credit} + {1'b0, r_win};
  assign w_card_ok   = bus.dcard_valid && rank_ok(bus.dcard_num);
  assign w_draw_v    = rank_value(bus.dcard_num);
  assign w_ref_v     = rank_value(r_ref);
  assign w_push      = (w_draw_v == w_ref_v);
  assign w_hit       = r_guess_hi ? (w_draw_v > w_ref_v) : (w_draw_v < w_ref_v);
  assign w_round_inc = r_round + 4'd1;

  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      r_state    <= IDLE;
      r_win      <= 16'd0;
      r_credit   <= 16'd0;
      r_dres     <= DRES_NONE;
      r_done     <= 1'b0;
      r_armed    <= 1'b1;
      r_guess_hi <= 1'b0;
      r_have_ref <= 1'b0;
      r_ref      <= 4'd0;
      r_round    <= 4'd0;
    end else begin
      r_done <= 1'b0;
      // A held result is counted once: re-arm only when the judge shows no result.
      if (bus.hand_r == HAND_IDLE) r_armed <= 1'b1;
      case (r_state)
        IDLE: begin
          if (r_armed && (bus.hand_r != HAND_IDLE)) begin
            r_armed    <= 1'b0;
            r_win      <= {4'd0, w_prod};
            r_dres     <= DRES_NONE;
            r_have_ref <= 1'b0;
            r_state    <= ((w_prod != 12'd0) && bus.dchance1) ? OFFER : COLLECT;
          end
        end
        OFFER: begin
          // After a round the drawn card is already the reference, so skip REF.
          if (bus.take)     r_state <= COLLECT;
          else if (bus.dbl) r_state <= r_have_ref ? GUESS : REF;
        end
        REF: begin
          if (w_card_ok) begin
            r_ref      <= bus.dcard_num;
            r_have_ref <= 1'b1;
            r_state    <= GUESS;
          end
        end
        GUESS: begin
          if (bus.guess_hi ^ bus.guess_lo) begin
            r_guess_hi <= bus.guess_hi;
            r_state    <= DRAW;
          end
        end
        DRAW: begin
          if (w_card_ok) begin
            if (w_push) begin
              r_dres  <= DRES_PUSH;
              r_ref   <= bus.dcard_num;
              r_state <= OFFER;
            end else if (w_hit) begin
              r_dres  <= DRES_WIN;
              r_win   <= w_win_dbl;
              r_round <= w_round_inc;
              r_ref   <= bus.dcard_num;
              r_state <= ((w_round_inc == LP_MAX_ROUNDS) || (w_win_dbl == WIN_MAX)) ? COLLECT : OFFER;
            end else begin
              r_dres  <= DRES_LOSE;
              r_win   <= 16'd0;
              r_state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          r_credit <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
          r_round  <= 4'd0;
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.win_amt    = r_win;
  assign bus.credit     = r_credit;
  assign bus.dresult    = r_dres;
  assign bus.done       = r_done;
  assign bus.offer      = (r_state == OFFER);
  assign bus.need_card  = (r_state == REF) || (r_state == DRAW);
  assign bus.need_guess = (r_state == GUESS);
  assign bus.busy       = (r_state != IDLE);
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_poker_payout.sv
// Directed and randomized bench for poker_payout against a rule-level reference model.
module tb_poker_payout;
  import poker_payout_pkg::*;

  logic clock = 1'b0;
  logic reset_c;
  int   n_pass   = 0;
  int   n_checks = 0;
  int   done_cnt = 0;

  // Reference model of the game, written from the payout and double-up rules.
  int     mult_tbl [16] = '{0, 1, 2, 3, 4, 5, 10, 20, 25, 0, 250, 0, 0, 0, 0, 0};
  int     m_credit;
  int     m_win;
  int     m_round;
  int     m_ref;
  int     m_dres;
  bit     m_hi;
  bit     m_have_ref;
  state_t m_state;

  poker_payout_if bus ();

  poker_payout #(.MAX_ROUNDS(10), .WIN_MAX(16'd50000)) dut (
    .clock   (clock),
    .reset_c (reset_c),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int rv(input int r);
    return (r == 1) ? 14 : r;
  endfunction

  task automatic model_reset();
    m_credit = 0; m_win = 0; m_round = 0; m_ref = 0; m_dres = 0;
    m_hi = 0; m_have_ref = 0; m_state = IDLE;
  endtask

  task automatic settle();
    step();
    m_credit = (m_credit + m_win > 65535) ? 65535 : m_credit + m_win;
    m_round  = 0;
    m_state  = IDLE;
    chk("settle_done", bus.done, 1);
    chk("settle_credit", bus.credit, m_credit);
    chk("settle_state", bus.dbg_state, m_state);
    chk("settle_busy", bus.busy, 0);
  endtask

  task automatic accept(input int h, input bit ch, input int b);
    bus.hand_r = 4'(h); bus.dchance1 = ch; bus.bet = 4'(b);
    step();
    bus.hand_r = HAND_IDLE; bus.dchance1 = 1'b0;
    m_win = mult_tbl[h] * b;
    m_dres = 0; m_round = 0; m_have_ref = 0;
    m_state = (m_win != 0 && ch) ? OFFER : COLLECT;
    chk("accept_win", bus.win_amt, m_win);
    chk("accept_state", bus.dbg_state, m_state);
    chk("accept_dresult", bus.dresult, 0);
    if (m_state == COLLECT) settle();
    else chk("accept_offer", bus.offer, 1);
  endtask

  task automatic take(input bit also_dbl);
    bus.take = 1'b1; bus.dbl = also_dbl;
    step();
    bus.take = 1'b0; bus.dbl = 1'b0;
    m_state = COLLECT;
    chk("take_state", bus.dbg_state, m_state);
    settle();
  endtask

  task automatic double_up();
    bus.dbl = 1'b1;
    step();
    bus.dbl = 1'b0;
    m_state = m_have_ref ? GUESS : REF;
    chk("dbl_state", bus.dbg_state, m_state);
    if (m_state == REF) chk("dbl_need_card", bus.need_card, 1);
    else                chk("dbl_need_guess", bus.need_guess, 1);
  endtask

  task automatic give_ref(input int r);
    bus.dcard_valid = 1'b1; bus.dcard_num = 4'(r);
    step();
    bus.dcard_valid = 1'b0;
    if (r >= 1 && r <= 13) begin
      m_ref = r; m_have_ref = 1; m_state = GUESS;
    end
    chk("ref_state", bus.dbg_state, m_state);
  endtask

  task automatic guess(input bit hi, input bit lo);
    bus.guess_hi = hi; bus.guess_lo = lo;
    step();
    bus.guess_hi = 1'b0; bus.guess_lo = 1'b0;
    if (hi != lo) begin
      m_hi = hi; m_state = DRAW;
    end
    chk("guess_state", bus.dbg_state, m_state);
  endtask

  task automatic draw(input int r);
    bus.dcard_valid = 1'b1; bus.dcard_num = 4'(r);
    step();
    bus.dcard_valid = 1'b0;
    if (r >= 1 && r <= 13) begin
      if (rv(r) == rv(m_ref)) begin
        m_dres = 3; m_ref = r; m_state = OFFER;
      end else if ((rv(r) > rv(m_ref)) == m_hi) begin
        m_win = (2 * m_win > 50000) ? 50000 : 2 * m_win;
        m_round++;
        m_dres = 1;
        m_ref = r;
        m_state = (m_round == 10 || m_win == 50000) ? COLLECT : OFFER;
      end else begin
        m_dres = 2; m_win = 0; m_state = COLLECT;
      end
    end
    chk("draw_win", bus.win_amt, m_win);
    chk("draw_dresult", bus.dresult, m_dres);
    chk("draw_state", bus.dbg_state, m_state);
    if (m_state == COLLECT) settle();
  endtask

  task automatic do_reset();
    reset_c = 1'b0;
    step();
    step();
    reset_c = 1'b1;
    model_reset();
  endtask

  task automatic royal_to_cap();
    accept(HAND_RSF, 1, 15);
    double_up(); give_ref(2); guess(1, 0); draw(5);
    double_up(); guess(1, 0); draw(9);
    double_up(); guess(1, 0); draw(12);
    double_up(); guess(1, 0); draw(1);
  endtask

  initial begin
    int d0;
    bus.hand_r = HAND_IDLE; bus.dchance1 = 1'b0; bus.bet = 4'd0;
    bus.take = 1'b0; bus.dbl = 1'b0; bus.guess_hi = 1'b0; bus.guess_lo = 1'b0;
    bus.dcard_num = 4'd0; bus.dcard_valid = 1'b0;
    model_reset();
    do_reset();
    chk("rst_win", bus.win_amt, 0);
    chk("rst_credit", bus.credit, 0);
    chk("rst_dresult", bus.dresult, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_state", bus.dbg_state, IDLE);
    chk("rst_busy", bus.busy, 0);

    // Reset in the middle of a game wipes credit immediately.
    accept(HAND_RSF, 0, 2);
    chk("credit_500", bus.credit, 500);
    accept(HAND_TWO_PAIR, 1, 3);
    double_up(); give_ref(5);
    #3 reset_c = 1'b0;
    #1;
    chk("midrst_credit", bus.credit, 0);
    chk("midrst_state", bus.dbg_state, IDLE);
    chk("midrst_busy", bus.busy, 0);
    step();
    reset_c = 1'b1;
    model_reset();

    // One pair held for three cycles settles exactly once.
    d0 = done_cnt;
    bus.hand_r = HAND_PAIR; bus.dchance1 = 1'b0; bus.bet = 4'd5;
    step();
    chk("pair_win", bus.win_amt, 5);
    chk("pair_state", bus.dbg_state, COLLECT);
    step();
    chk("pair_done", bus.done, 1);
    chk("pair_credit", bus.credit, 5);
    step();
    bus.hand_r = HAND_IDLE;
    step(); step();
    chk("pair_done_once", done_cnt - d0, 1);
    chk("pair_idle", bus.dbg_state, IDLE);
    m_credit = 5;

    // Double-up win, then collect.
    accept(HAND_TRIPS, 1, 10);
    double_up(); give_ref(7); guess(1, 0); draw(1);
    chk("dup_win60", bus.win_amt, 60);
    take(0);

    // Push, then loss.
    accept(HAND_FLUSH, 1, 2);
    double_up(); give_ref(9); guess(0, 1); draw(9);
    double_up(); guess(0, 1); draw(12);

    // Win cap forces collect; a second capped run saturates credit.
    do_reset();
    royal_to_cap();
    chk("cap_credit", bus.credit, 50000);
    royal_to_cap();
    chk("sat_credit", bus.credit, 65535);

    // Round limit forces collect after the tenth win.
    do_reset();
    accept(HAND_PAIR, 1, 1);
    double_up(); give_ref(2);
    for (int i = 0; i < 10; i++) begin
      if (i != 0) double_up();
      if (m_ref <= 7) begin guess(1, 0); draw(13); end
      else            begin guess(0, 1); draw(2);  end
    end
    chk("rounds_credit", bus.credit, 1024);

    // Illegal and conflicting inputs.
    accept(4'b1011, 1, 5);
    accept(HAND_PAIR, 1, 4);
    take(1);
    accept(HAND_PAIR, 1, 4);
    double_up(); give_ref(0); give_ref(15); give_ref(6);
    guess(1, 1); guess(0, 0); guess(0, 1); draw(14); draw(3);
    take(0);

    // Randomized hands and double-up sessions.
    for (int n = 0; n < 40; n++) begin
      int code;
      int bet_v;
      int budget;
      bit hi;
      code  = $urandom_range(0, 14);
      bet_v = $urandom_range(0, 15);
      accept(code, 1'($urandom_range(0, 1)), bet_v);
      budget = 0;
      while (m_state == OFFER) begin
        budget++;
        if (budget > 12 || $urandom_range(0, 3) == 0) begin
          take(1'($urandom_range(0, 1)));
        end else begin
          double_up();
          if (m_state == REF) give_ref($urandom_range(1, 13));
          hi = 1'($urandom_range(0, 1));
          guess(hi, !hi);
          draw($urandom_range(1, 13));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
